// File: rtl/fpu_req_arbiter_pkg.sv
// Shared types and width helpers for the FPU request arbiter and its tag table.
package fpu_req_arbiter_pkg;

  localparam int MAX_PENDING_DEF = 8;
  localparam int TAG_BITS        = $clog2(MAX_PENDING_DEF);

  typedef logic [TAG_BITS-1:0] fpu_arb_tag_t;

  // Owner index width; a single requester still needs one bit to index with.
  function automatic int owner_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_tag_table.sv
// Tag allocator: free bitmap, per-tag owner, lowest-free encoder and in-flight counter.
module fpu_tag_table
  import fpu_req_arbiter_pkg::*;
#(
  parameter int  NUM_REQS    = 4,
  parameter int  MAX_PENDING = 8,
  localparam int TW          = $clog2(MAX_PENDING),
  localparam int OW          = owner_bits(NUM_REQS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic [OW-1:0] alloc_owner,
  output logic [TW-1:0] alloc_tag,
  input  logic          free,
  input  logic [TW-1:0] free_tag,
  input  logic [TW-1:0] lookup_tag,
  output logic          lookup_busy,
  output logic [OW-1:0] lookup_owner,
  output logic          full,
  output logic [TW:0]   pending_count
);

  logic [MAX_PENDING-1:0] busy_q;
  logic [OW-1:0]          owner_q [MAX_PENDING];
  logic [TW:0]            count_q;

  // Allocation only ever looks at the registered bitmap, so a tag freed this
  // cycle cannot be handed out again until the next one.
  always_comb begin
    alloc_tag = '0;
    for (int i = MAX_PENDING - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = TW'(i);
    end
  end

  assign full          = (count_q == (TW+1)'(MAX_PENDING));
  assign pending_count = count_q;
  assign lookup_busy   = busy_q[lookup_tag];
  assign lookup_owner  = owner_q[lookup_tag];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc) busy_q[alloc_tag] <= 1'b1;
      if (free)  busy_q[free_tag]  <= 1'b0;
      count_q <= count_q + (TW+1)'(alloc) - (TW+1)'(free);
    end
  end

  // Owner entries are only read while the tag is marked busy.
  always_ff @(posedge clk) begin
    if (alloc) owner_q[alloc_tag] <= alloc_owner;
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(alloc && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(free && (count_q == '0)));
  a_free_busy:    assert property (@(posedge clk) disable iff (reset) free |-> busy_q[free_tag]);
  a_count_bound:  assert property (@(posedge clk) disable iff (reset) count_q <= (TW+1)'(MAX_PENDING));

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one FPU channel; responses routed back by tag owner.
module fpu_req_arbiter
  import fpu_req_arbiter_pkg::*;
#(
  parameter int  NUM_REQS    = 4,
  parameter int  REQ_DATAW   = 256,
  parameter int  RSP_DATAW   = 128,
  parameter int  MAX_PENDING = 8,
  localparam int TW          = $clog2(MAX_PENDING),
  localparam int OW          = owner_bits(NUM_REQS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          fpu_req_valid,
  output logic [REQ_DATAW-1:0]          fpu_req_data,
  output logic [TW-1:0]                 fpu_req_tag,
  input  logic                          fpu_req_ready,
  input  logic                          fpu_rsp_valid,
  input  logic [RSP_DATAW-1:0]          fpu_rsp_data,
  input  logic [TW-1:0]                 fpu_rsp_tag,
  output logic                          fpu_rsp_ready,
  output logic [NUM_REQS-1:0]           rsp_valid,
  output logic [RSP_DATAW-1:0]          rsp_data,
  input  logic [NUM_REQS-1:0]           rsp_ready,
  output logic [TW:0]                   pending_count,
  output logic                          busy
);

  logic [OW-1:0] rr_ptr_q;
  logic          lock_q;
  logic [OW-1:0] lock_idx_q;
  logic [OW-1:0] winner;
  logic          any_valid;
  logic          full;
  logic          fire;
  logic          rsp_known;
  logic [OW-1:0] rsp_owner;
  logic          rsp_hit;
  logic          rsp_fire;
  int            idx;

  // A stalled grant stays with its winner until the FPU takes it.
  always_comb begin
    winner    = lock_idx_q;
    any_valid = 1'b0;
    idx       = 0;
    if (lock_q) begin
      any_valid = req_valid[lock_idx_q];
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQS) idx = idx - NUM_REQS;
        if (!any_valid && req_valid[idx]) begin
          any_valid = 1'b1;
          winner    = OW'(idx);
        end
      end
    end
  end

  assign fpu_req_valid = any_valid & ~full & ~reset;
  assign fire          = fpu_req_valid & fpu_req_ready;
  assign fpu_req_data  = req_data[int'(winner)*REQ_DATAW +: REQ_DATAW];

  always_comb begin
    req_ready         = '0;
    req_ready[winner] = fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= fpu_req_valid & ~fpu_req_ready;
      if (fpu_req_valid && !fpu_req_ready) lock_idx_q <= winner;
      if (fire) rr_ptr_q <= (int'(winner) == NUM_REQS - 1) ? '0 : winner + 1'b1;
    end
  end

  // Responses on an unallocated tag are swallowed so the FPU cannot stall on them.
  assign rsp_hit       = fpu_rsp_valid & rsp_known & ~reset;
  assign rsp_fire      = rsp_hit & rsp_ready[rsp_owner];
  assign fpu_rsp_ready = fpu_rsp_valid & ~reset & (rsp_known ? rsp_ready[rsp_owner] : 1'b1);
  assign rsp_data      = fpu_rsp_data;

  always_comb begin
    rsp_valid = '0;
    if (rsp_hit) rsp_valid[rsp_owner] = 1'b1;
  end

  fpu_tag_table #(
    .NUM_REQS    (NUM_REQS),
    .MAX_PENDING (MAX_PENDING)
  ) u_tag_table (
    .clk           (clk),
    .reset         (reset),
    .alloc         (fire),
    .alloc_owner   (winner),
    .alloc_tag     (fpu_req_tag),
    .free          (rsp_fire),
    .free_tag      (fpu_rsp_tag),
    .lookup_tag    (fpu_rsp_tag),
    .lookup_busy   (rsp_known),
    .lookup_owner  (rsp_owner),
    .full          (full),
    .pending_count (pending_count)
  );

  assign busy = (pending_count != '0);

  a_rsp_tag_allocated: assert property (@(posedge clk) disable iff (reset) fpu_rsp_valid |-> rsp_known);

endmodule
